// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the RV32I hazard controller: PC mux select, forwarding select and FSM state.
package pipeline_hazard_ctrl_pkg;

    localparam int CNT_W_DEF     = 32;
    localparam int REG_IDX_W_DEF = 5;

    typedef enum logic [1:0] {
        PCMUX_PC_PLUS4 = 2'b00,
        PCMUX_ALU_OUT  = 2'b01,
        PCMUX_ALU_MOD2 = 2'b10
    } pcmux_sel_t;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_MEM_WB = 2'b10
    } fwdmux_sel_t;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle; master is the datapath side, slave the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W     = 32,
    parameter int REG_IDX_W = 5
);
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1, id_rs2;
    logic                 id_use_rs1, id_use_rs2;
    logic                 ex_valid;
    logic [REG_IDX_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic                 ex_is_load, ex_br_taken, ex_is_jal, ex_is_jalr;
    logic [REG_IDX_W-1:0] mem_rd, wb_rd;
    logic                 mem_regwrite, wb_regwrite;
    logic                 imem_read, imem_resp, dmem_req, dmem_resp;

    pcmux_sel_t           pcmux_sel;
    logic                 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic                 flush_if_id, flush_id_ex;
    fwdmux_sel_t          fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0]     stall_cycles, flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_is_load, ex_br_taken, ex_is_jal, ex_is_jalr, mem_rd, wb_rd,
               mem_regwrite, wb_regwrite, imem_read, imem_resp, dmem_req, dmem_resp,
        input  pcmux_sel, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_is_load, ex_br_taken, ex_is_jal, ex_is_jalr, mem_rd, wb_rd,
               mem_regwrite, wb_regwrite, imem_read, imem_resp, dmem_req, dmem_resp,
        output pcmux_sel, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forwarding compare for one ALU operand; purely combinational, EX/MEM beats MEM/WB, x0 never forwarded.
module pipeline_hazard_ctrl_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] ex_rs_i,
    input  logic [REG_IDX_W-1:0] mem_rd_i,
    input  logic                 mem_regwrite_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    input  logic                 wb_regwrite_i,
    output fwdmux_sel_t          sel_o
);
    always_comb begin
        sel_o = FWD_NONE;
        if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
            sel_o = FWD_EX_MEM;
        end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
            sel_o = FWD_MEM_WB;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: same-cycle stage enables/flushes/PC select, priority memory stall > redirect > load-use.
// A redirect seen during a memory stall is held and applied on the first unstalled cycle.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic             pend_q, pend_d, pend_jalr_q, pend_jalr_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

    logic        mem_stall, redirect_now, load_use, apply_redirect, use_jalr;
    logic        load_front, load_back, flush_if, flush_ex;
    pcmux_sel_t  pcmux_sel;
    fwdmux_sel_t fwd_a, fwd_b;

    always_comb begin
        mem_stall    = (bus.imem_read & ~bus.imem_resp) | (bus.dmem_req & ~bus.dmem_resp);
        redirect_now = bus.ex_valid & (bus.ex_br_taken | bus.ex_is_jal | bus.ex_is_jalr);
        // Gating on LOAD_STALL keeps the bubble to exactly one cycle even if ID/EX is slow to clear.
        load_use     = (state_q != LOAD_STALL) & bus.ex_valid & bus.ex_is_load & (bus.ex_rd != '0) &
                       ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                        (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
        apply_redirect = ~mem_stall & (redirect_now | pend_q);
        use_jalr       = pend_q ? pend_jalr_q : bus.ex_is_jalr;

        pcmux_sel   = PCMUX_PC_PLUS4;
        load_front  = 1'b1;
        load_back   = 1'b1;
        flush_if    = 1'b0;
        flush_ex    = 1'b0;
        state_d     = RUN;
        pend_d      = pend_q;
        pend_jalr_d = pend_jalr_q;
        flush_d     = flush_q;

        if (rst) begin
            flush_if = 1'b1;
            flush_ex = 1'b1;
        end else if (mem_stall) begin
            load_front = 1'b0;
            load_back  = 1'b0;
            state_d    = MEM_WAIT;
            if (redirect_now && !pend_q) begin
                pend_d      = 1'b1;
                pend_jalr_d = bus.ex_is_jalr;
            end
        end else if (apply_redirect) begin
            pcmux_sel = use_jalr ? PCMUX_ALU_MOD2 : PCMUX_ALU_OUT;
            flush_if  = 1'b1;
            flush_ex  = 1'b1;
            pend_d    = 1'b0;
            flush_d   = flush_q + CNT_W'(1);
        end else if (load_use) begin
            load_front = 1'b0;
            flush_ex   = 1'b1;
            state_d    = LOAD_STALL;
        end

        stall_d = load_front ? stall_q : stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pend_q      <= 1'b0;
            pend_jalr_q <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_jalr_q <= pend_jalr_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

    pipeline_hazard_ctrl_fwd_unit #(.REG_IDX_W(REG_IDX_W)) u_fwd_a (
        .ex_rs_i(bus.ex_rs1), .mem_rd_i(bus.mem_rd), .mem_regwrite_i(bus.mem_regwrite),
        .wb_rd_i(bus.wb_rd), .wb_regwrite_i(bus.wb_regwrite), .sel_o(fwd_a)
    );

    pipeline_hazard_ctrl_fwd_unit #(.REG_IDX_W(REG_IDX_W)) u_fwd_b (
        .ex_rs_i(bus.ex_rs2), .mem_rd_i(bus.mem_rd), .mem_regwrite_i(bus.mem_regwrite),
        .wb_rd_i(bus.wb_rd), .wb_regwrite_i(bus.wb_regwrite), .sel_o(fwd_b)
    );

    assign bus.pcmux_sel    = pcmux_sel;
    assign bus.load_pc      = load_front;
    assign bus.load_if_id   = load_front;
    assign bus.load_id_ex   = load_back;
    assign bus.load_ex_mem  = load_back;
    assign bus.load_mem_wb  = load_back;
    assign bus.flush_if_id  = flush_if;
    assign bus.flush_id_ex  = flush_ex;
    assign bus.fwd_a_sel    = rst ? FWD_NONE : fwd_a;
    assign bus.fwd_b_sel    = rst ? FWD_NONE : fwd_b;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32), .REG_IDX_W(5)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(32), .REG_IDX_W(5)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [4:0] loads;
    logic [1:0] flushes;
    assign loads   = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb};
    assign flushes = {bus.flush_if_id, bus.flush_id_ex};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.id_rs1 = 5'd0;  bus.id_rs2 = 5'd0;  bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0; bus.ex_rd = 5'd0;
        bus.ex_is_load = 1'b0; bus.ex_br_taken = 1'b0; bus.ex_is_jal = 1'b0; bus.ex_is_jalr = 1'b0;
        bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b0;
        bus.imem_read = 1'b0; bus.imem_resp = 1'b0; bus.dmem_req = 1'b0; bus.dmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_rs1 = 5'd3;
        bus.mem_rd = 5'd3; bus.mem_regwrite = 1'b1;
        #2;
        checks++;
        if (bus.pcmux_sel !== PCMUX_PC_PLUS4 || loads !== 5'b11111 || flushes !== 2'b11) begin
            errors++;
            $display("FAIL reset_outputs: pcmux=%0d loads=%b flush=%b, want 0 11111 11",
                     bus.pcmux_sel, loads, flushes);
        end
        checks++;
        if (bus.fwd_a_sel !== FWD_NONE) begin
            errors++;
            $display("FAIL reset_fwd: got %0d want 0", bus.fwd_a_sel);
        end
        tick();
        tick();
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0 || dut.state_q !== RUN) begin
            errors++;
            $display("FAIL reset_state: stall=%0d flush=%0d state=%0d, want 0 0 RUN",
                     bus.stall_cycles, bus.flush_count, dut.state_q);
        end
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_load_use();
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1; bus.id_rs2 = 5'd1; bus.id_use_rs2 = 1'b1;
        #2;
        checks++;
        if (loads !== 5'b00111 || flushes !== 2'b01 || bus.pcmux_sel !== PCMUX_PC_PLUS4) begin
            errors++;
            $display("FAIL load_use_stall: loads=%b flush=%b pcmux=%0d, want 00111 01 0",
                     loads, flushes, bus.pcmux_sel);
        end
        tick();
        exp_stall = 1;
        checks++;
        if (dut.state_q !== LOAD_STALL || bus.stall_cycles !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL load_use_state: state=%0d stall=%0d, want LOAD_STALL %0d",
                     dut.state_q, bus.stall_cycles, exp_stall);
        end
        bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0;
        #2;
        checks++;
        if (loads !== 5'b11111 || flushes !== 2'b00) begin
            errors++;
            $display("FAIL load_use_release: loads=%b flush=%b, want 11111 00", loads, flushes);
        end
        tick();
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_rs1 = 5'd5; bus.ex_rs2 = 5'd1;
        bus.wb_rd = 5'd5; bus.wb_regwrite = 1'b1;
        #2;
        checks++;
        if (bus.fwd_a_sel !== FWD_MEM_WB || bus.fwd_b_sel !== FWD_NONE || dut.state_q !== RUN) begin
            errors++;
            $display("FAIL load_use_fwd: a=%0d b=%0d state=%0d, want 2 0 RUN",
                     bus.fwd_a_sel, bus.fwd_b_sel, dut.state_q);
        end
        // Load into x0 and load whose rd the ID instruction does not read: no stall
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
        #2;
        checks++;
        if (bus.load_pc !== 1'b1 || bus.flush_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL load_x0: load_pc=%b flush_id_ex=%b, want 1 0", bus.load_pc, bus.flush_id_ex);
        end
        bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b0;
        #1;
        checks++;
        if (bus.load_pc !== 1'b1) begin
            errors++;
            $display("FAIL load_unused_rs: load_pc=%b want 1", bus.load_pc);
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch();
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_br_taken = 1'b1;
        #2;
        checks++;
        if (bus.pcmux_sel !== PCMUX_ALU_OUT || flushes !== 2'b11 || loads !== 5'b11111) begin
            errors++;
            $display("FAIL branch_taken: pcmux=%0d flush=%b loads=%b, want 1 11 11111",
                     bus.pcmux_sel, flushes, loads);
        end
        tick();
        exp_flush++;
        set_idle();
        bus.ex_br_taken = 1'b1;
        #2;
        checks++;
        if (bus.flush_count !== 32'(exp_flush) || flushes !== 2'b00 || bus.pcmux_sel !== PCMUX_PC_PLUS4) begin
            errors++;
            $display("FAIL branch_after: flush_count=%0d flush=%b pcmux=%0d, want %0d 00 0",
                     bus.flush_count, flushes, bus.pcmux_sel, exp_flush);
        end
        bus.ex_br_taken = 1'b0; bus.ex_valid = 1'b1; bus.ex_is_jal = 1'b1;
        #1;
        checks++;
        if (bus.pcmux_sel !== PCMUX_ALU_OUT || flushes !== 2'b11) begin
            errors++;
            $display("FAIL jal: pcmux=%0d flush=%b, want 1 11", bus.pcmux_sel, flushes);
        end
        tick();
        exp_flush++;
        set_idle();
        #1;
        checks++;
        if (bus.flush_count !== 32'(exp_flush)) begin
            errors++;
            $display("FAIL jal_count: got %0d want %0d", bus.flush_count, exp_flush);
        end
    endtask

    task automatic test_mem_stall_redirect();
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_is_jalr = 1'b1; bus.dmem_req = 1'b1; bus.dmem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (loads !== 5'b00000 || flushes !== 2'b00) begin
                errors++;
                $display("FAIL mem_stall_cyc%0d: loads=%b flush=%b, want 00000 00", i, loads, flushes);
            end
            tick();
        end
        exp_stall += 3;
        bus.dmem_resp = 1'b1;
        #2;
        checks++;
        if (bus.pcmux_sel !== PCMUX_ALU_MOD2 || flushes !== 2'b11 || loads !== 5'b11111 ||
            dut.state_q !== MEM_WAIT) begin
            errors++;
            $display("FAIL jalr_release: pcmux=%0d flush=%b loads=%b state=%0d, want 2 11 11111 MEM_WAIT",
                     bus.pcmux_sel, flushes, loads, dut.state_q);
        end
        tick();
        exp_flush++;
        set_idle();
        #1;
        checks++;
        if (bus.flush_count !== 32'(exp_flush) || bus.stall_cycles !== 32'(exp_stall) || dut.state_q !== RUN) begin
            errors++;
            $display("FAIL jalr_counts: flush=%0d stall=%0d state=%0d, want %0d %0d RUN",
                     bus.flush_count, bus.stall_cycles, dut.state_q, exp_flush, exp_stall);
        end
        // Held jalr kind applies even once EX no longer shows it; fetch-side stall this time
        bus.ex_valid = 1'b1; bus.ex_is_jalr = 1'b1; bus.imem_read = 1'b1; bus.imem_resp = 1'b0;
        #1;
        checks++;
        if (loads !== 5'b00000) begin
            errors++;
            $display("FAIL imem_stall: loads=%b want 00000", loads);
        end
        tick();
        exp_stall++;
        bus.ex_valid = 1'b0; bus.ex_is_jalr = 1'b0; bus.imem_resp = 1'b1;
        #1;
        checks++;
        if (bus.pcmux_sel !== PCMUX_ALU_MOD2 || flushes !== 2'b11) begin
            errors++;
            $display("FAIL pending_kind: pcmux=%0d flush=%b, want 2 11", bus.pcmux_sel, flushes);
        end
        tick();
        exp_flush++;
        set_idle();
        #1;
        checks++;
        if (bus.flush_count !== 32'(exp_flush) || bus.stall_cycles !== 32'(exp_stall) || flushes !== 2'b00) begin
            errors++;
            $display("FAIL pending_clear: flush=%0d stall=%0d fl=%b, want %0d %0d 00",
                     bus.flush_count, bus.stall_cycles, flushes, exp_flush, exp_stall);
        end
    endtask

    task automatic test_forwarding();
        set_idle();
        bus.mem_rd = 5'd7; bus.wb_rd = 5'd7; bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd0;
        bus.mem_regwrite = 1'b1; bus.wb_regwrite = 1'b1;
        #1;
        checks++;
        if (bus.fwd_a_sel !== FWD_EX_MEM || bus.fwd_b_sel !== FWD_NONE) begin
            errors++;
            $display("FAIL fwd_priority: a=%0d b=%0d, want 1 0", bus.fwd_a_sel, bus.fwd_b_sel);
        end
        bus.mem_regwrite = 1'b0; bus.ex_rs2 = 5'd7;
        #1;
        checks++;
        if (bus.fwd_a_sel !== FWD_MEM_WB || bus.fwd_b_sel !== FWD_MEM_WB) begin
            errors++;
            $display("FAIL fwd_wb: a=%0d b=%0d, want 2 2", bus.fwd_a_sel, bus.fwd_b_sel);
        end
        bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd12;
        bus.mem_regwrite = 1'b1;
        #1;
        checks++;
        if (bus.fwd_a_sel !== FWD_NONE || bus.fwd_b_sel !== FWD_NONE) begin
            errors++;
            $display("FAIL fwd_x0: a=%0d b=%0d, want 0 0", bus.fwd_a_sel, bus.fwd_b_sel);
        end
        bus.mem_rd = 5'd12;
        #1;
        checks++;
        if (bus.fwd_a_sel !== FWD_NONE || bus.fwd_b_sel !== FWD_EX_MEM) begin
            errors++;
            $display("FAIL fwd_b_exmem: a=%0d b=%0d, want 0 1", bus.fwd_a_sel, bus.fwd_b_sel);
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd4; bus.ex_br_taken = 1'b1;
        bus.id_rs2 = 5'd4; bus.id_use_rs2 = 1'b1;
        #2;
        checks++;
        if (bus.pcmux_sel !== PCMUX_ALU_OUT || bus.load_pc !== 1'b1 || flushes !== 2'b11) begin
            errors++;
            $display("FAIL redirect_vs_load_use: pcmux=%0d load_pc=%b flush=%b, want 1 1 11",
                     bus.pcmux_sel, bus.load_pc, flushes);
        end
        tick();
        exp_flush++;
        set_idle();
        #1;
        checks++;
        if (dut.state_q !== RUN || bus.flush_count !== 32'(exp_flush) || bus.stall_cycles !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL redirect_vs_load_use_state: state=%0d flush=%0d stall=%0d, want RUN %0d %0d",
                     dut.state_q, bus.flush_count, bus.stall_cycles, exp_flush, exp_stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.dmem_req = 1'b1; bus.dmem_resp = 1'b0;
        tick();
        tick();
        exp_stall += 2;
        checks++;
        if (dut.state_q !== MEM_WAIT || bus.stall_cycles !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL pre_reset: state=%0d stall=%0d, want MEM_WAIT %0d",
                     dut.state_q, bus.stall_cycles, exp_stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 2'b11 || bus.pcmux_sel !== PCMUX_PC_PLUS4) begin
            errors++;
            $display("FAIL reset_in_stall: loads=%b flush=%b pcmux=%0d, want 11111 11 0",
                     loads, flushes, bus.pcmux_sel);
        end
        tick();
        rst = 1'b0;
        set_idle();
        exp_stall = 0;
        exp_flush = 0;
        #1;
        checks++;
        if (dut.state_q !== RUN || bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0 ||
            flushes !== 2'b00 || bus.pcmux_sel !== PCMUX_PC_PLUS4) begin
            errors++;
            $display("FAIL reset_abandon: state=%0d stall=%0d flush=%0d fl=%b pcmux=%0d, want RUN 0 0 00 0",
                     dut.state_q, bus.stall_cycles, bus.flush_count, flushes, bus.pcmux_sel);
        end
        tick();
        checks++;
        if (bus.flush_count !== 32'd0 || bus.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL pending_dropped: flush=%0d stall=%0d, want 0 0", bus.flush_count, bus.stall_cycles);
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_stall_redirect();
        test_forwarding();
        test_back_to_back();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
